// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter: FSM state encoding, default
//   widths, the IO-space address marker and the funct3 load-type codes.
package mem_arbiter_pkg;

  localparam int         ADDR_WIDTH_DEF   = 32;
  localparam int         LSB_ID_WIDTH_DEF = 4;
  localparam logic [1:0] IO_BASE_HI_DEF   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_arbiter_load_ext.sv
// load_ext
//   Combinational sign/zero extension of a raw engine word according to the
//   RISC-V load funct3 code.
//   Ports:
//     funct3 in  3  : load type (lb, lh, lw, lbu, lhu)
//     raw    in  32 : raw word from the memory engine (data in the low bits)
//     ext    out 32 : extended result
module load_ext
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = raw[7:0];
  assign half_s = raw[15:0];

  always_comb begin
    ext = raw;
    case (funct3)
      F3_LB:   ext = 32'(byte_s);
      F3_LH:   ext = 32'(half_s);
      F3_LBU:  ext = {24'd0, raw[7:0]};
      F3_LHU:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the byte-serial memory engine between the icache (refills) and the
//   load/store buffer. One request is latched, issued to the engine, and the
//   response is routed back to its owner. Flush discards icache/load responses;
//   IO stores wait while the IO buffer is full.
//   Ports:
//     clk, rst_n_in (async, active-low), rdy_in (global enable),
//     flush_in, io_buffer_full
//     icache : ic_req, ic_addr -> ic_grant, ic_resp, ic_data
//     lsb    : lsb_req, lsb_we, lsb_addr, lsb_wdata, lsb_type, lsb_id
//              -> lsb_grant, lsb_resp, lsb_resp_id, lsb_rdata
//     engine : eng_start, eng_we, eng_addr, eng_wdata, eng_type <- eng_done, eng_rdata
//     busy   : FSM not idle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int         LSB_ID_WIDTH = LSB_ID_WIDTH_DEF,
  parameter int         STARVE_MAX   = 4,
  parameter logic [1:0] IO_BASE_HI   = IO_BASE_HI_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    io_buffer_full,
  input  logic                    ic_req,
  input  logic [ADDR_WIDTH-1:0]   ic_addr,
  output logic                    ic_grant,
  output logic                    ic_resp,
  output logic [31:0]             ic_data,
  input  logic                    lsb_req,
  input  logic                    lsb_we,
  input  logic [ADDR_WIDTH-1:0]   lsb_addr,
  input  logic [31:0]             lsb_wdata,
  input  logic [2:0]              lsb_type,
  input  logic [LSB_ID_WIDTH-1:0] lsb_id,
  output logic                    lsb_grant,
  output logic                    lsb_resp,
  output logic [LSB_ID_WIDTH-1:0] lsb_resp_id,
  output logic [31:0]             lsb_rdata,
  output logic                    eng_start,
  output logic                    eng_we,
  output logic [ADDR_WIDTH-1:0]   eng_addr,
  output logic [31:0]             eng_wdata,
  output logic [2:0]              eng_type,
  input  logic                    eng_done,
  input  logic [31:0]             eng_rdata,
  output logic                    busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_t                  state_q, state_d;
  logic                    owner_lsb_q;
  logic                    discard_q;
  logic [CNT_W-1:0]        starve_q, starve_d;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [2:0]              type_q;
  logic [LSB_ID_WIDTH-1:0] id_q;
  logic [31:0]             rdata_q;
  logic [31:0]             ext_rdata;

  logic lsb_ok, starved, take_ic, take_lsb;

  // A store into IO space cannot be accepted while the IO sink is full; it is
  // simply ineligible, so a waiting icache request may go first.
  assign lsb_ok  = lsb_req &&
                   !(lsb_we && (lsb_addr[17:16] == IO_BASE_HI) && io_buffer_full);
  assign starved = (starve_q == CNT_W'(STARVE_MAX));

  always_comb begin
    state_d  = state_q;
    take_ic  = 1'b0;
    take_lsb = 1'b0;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush_in) begin
          if (ic_req && (!lsb_ok || starved)) take_ic = 1'b1;
          else if (lsb_ok)                    take_lsb = 1'b1;
        end
        if (take_ic || take_lsb) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (eng_done) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Starvation counter tracks LSB grants won while icache is kept waiting.
    if (!ic_req || take_ic)       starve_d = '0;
    else if (take_lsb && !starved) starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      owner_lsb_q <= 1'b0;
      discard_q   <= 1'b0;
      starve_q    <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      type_q      <= '0;
      id_q        <= '0;
      rdata_q     <= '0;
    end else if (rdy_in) begin
      state_q  <= state_d;
      starve_q <= starve_d;
      // Request latch: requester may change its fields after the grant.
      if (take_ic) begin
        owner_lsb_q <= 1'b0;
        we_q        <= 1'b0;
        addr_q      <= ic_addr;
        wdata_q     <= '0;
        type_q      <= F3_LW;
        id_q        <= '0;
      end else if (take_lsb) begin
        owner_lsb_q <= 1'b1;
        we_q        <= lsb_we;
        addr_q      <= lsb_addr;
        wdata_q     <= lsb_wdata;
        type_q      <= lsb_type;
        id_q        <= lsb_id;
      end
      // Engine completion capture.
      if (state_q == ST_WAIT && eng_done) rdata_q <= eng_rdata;
      // Committed stores must still complete visibly, so only reads discard.
      if (state_q == ST_RESP)
        discard_q <= 1'b0;
      else if (flush_in && state_q != ST_IDLE && (!owner_lsb_q || !we_q))
        discard_q <= 1'b1;
    end
  end

  load_ext u_load_ext (
    .funct3 (type_q),
    .raw    (rdata_q),
    .ext    (ext_rdata)
  );

  // Outputs decode straight from held state, so a frozen FSM extends pulses.
  assign busy        = (state_q != ST_IDLE);
  assign eng_start   = (state_q == ST_ISSUE);
  assign ic_grant    = eng_start && !owner_lsb_q;
  assign lsb_grant   = eng_start && owner_lsb_q;
  assign ic_resp     = (state_q == ST_RESP) && !owner_lsb_q && !discard_q;
  assign lsb_resp    = (state_q == ST_RESP) && owner_lsb_q && !discard_q;
  assign ic_data     = ic_resp ? rdata_q : 32'd0;
  assign lsb_rdata   = (lsb_resp && !we_q) ? ext_rdata : 32'd0;
  assign lsb_resp_id = lsb_resp ? id_q : '0;
  assign eng_we      = we_q;
  assign eng_addr    = addr_q;
  assign eng_wdata   = wdata_q;
  assign eng_type    = type_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        flush_in = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_grant, ic_resp;
  logic [31:0] ic_data;
  logic        lsb_req = 1'b0;
  logic        lsb_we = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_wdata = '0;
  logic [2:0]  lsb_type = '0;
  logic [3:0]  lsb_id = '0;
  logic        lsb_grant, lsb_resp;
  logic [3:0]  lsb_resp_id;
  logic [31:0] lsb_rdata;
  logic        eng_start, eng_we;
  logic [31:0] eng_addr, eng_wdata;
  logic [2:0]  eng_type;
  logic        eng_done = 1'b0;
  logic [31:0] eng_rdata = '0;
  logic        busy;

  mem_arbiter dut (
    .clk(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush_in),
    .io_buffer_full(io_buffer_full),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant), .ic_resp(ic_resp),
    .ic_data(ic_data),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_type(lsb_type), .lsb_id(lsb_id), .lsb_grant(lsb_grant), .lsb_resp(lsb_resp),
    .lsb_resp_id(lsb_resp_id), .lsb_rdata(lsb_rdata),
    .eng_start(eng_start), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_type(eng_type), .eng_done(eng_done), .eng_rdata(eng_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lsb;
    logic [31:0] data;
    logic [3:0]  id;
  } resp_t;

  resp_t resp_q[$];
  bit    grant_q[$];
  int    nvec = 0;
  int    nerr = 0;
  int    cyc = 0;
  int    ngrant = 0;
  int    last_ic_resp_cyc = 0;
  int    eng_lat = 4;
  bit    fix_en = 1'b0;
  logic [31:0] fix_val = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic outs_any();
    return |{ic_grant, ic_resp, ic_data, lsb_grant, lsb_resp, lsb_resp_id, lsb_rdata,
             eng_start, eng_we, eng_addr, eng_wdata, eng_type, busy};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: accepts a start, returns done eng_lat cycles later.
  int          e_cnt = 0;
  logic [31:0] e_val = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      e_cnt = 0;
      eng_done = 1'b0;
    end else if (rdy) begin
      if (eng_done) eng_done = 1'b0;
      if (e_cnt > 0) begin
        e_cnt--;
        if (e_cnt == 0) begin
          eng_done = 1'b1;
          eng_rdata = e_val;
        end
      end else if (eng_start) begin
        e_cnt = eng_lat;
        e_val = eng_we ? 32'hDEADBEEF : (fix_en ? fix_val : model_rd(eng_addr));
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    bit    g;
    resp_t r;
    if (rst_n && rdy) begin
      if (ic_grant || lsb_grant) begin
        ngrant++;
        if (grant_q.size() == 0) chk("grant_unexp", 64'({ic_grant, lsb_grant}), 64'd0);
        else begin
          g = grant_q.pop_front();
          chk("grant_src", 64'(lsb_grant), 64'(g));
          chk("grant_onehot", 64'(ic_grant & lsb_grant), 64'd0);
        end
      end
      if (ic_resp || lsb_resp) begin
        if (ic_resp) last_ic_resp_cyc = cyc;
        if (resp_q.size() == 0) chk("resp_unexp", 64'({ic_resp, lsb_resp}), 64'd0);
        else begin
          r = resp_q.pop_front();
          chk("resp_src", 64'(lsb_resp), 64'(r.lsb));
          chk("resp_data", 64'(lsb_resp ? lsb_rdata : ic_data), 64'(r.data));
          if (r.lsb) chk("resp_id", 64'(lsb_resp_id), 64'(r.id));
        end
      end
    end
  end

  task automatic push_resp(input logic l, input logic [31:0] d, input logic [3:0] id);
    resp_t r;
    r.lsb = l; r.data = d; r.id = id;
    resp_q.push_back(r);
  endtask

  task automatic wait_grant(input bit want_lsb, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (want_lsb ? lsb_grant : ic_grant) begin seen = 1'b1; break; end
    end
    if (!seen) chk({"timeout_grant_", tag}, 64'd1, 64'd0);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (!busy && resp_q.size() == 0 && grant_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk({"timeout_idle_", tag}, 64'd1, 64'd0);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (eng_done) begin seen = 1'b1; break; end
    end
    if (!seen) chk({"timeout_done_", tag}, 64'd1, 64'd0);
  endtask

  task automatic do_ic(input logic [31:0] a, input logic [31:0] d, output int lat);
    int t0;
    fix_en = 1'b1; fix_val = d;
    grant_q.push_back(1'b0);
    push_resp(1'b0, d, 4'd0);
    @(posedge clk); #1;
    t0 = cyc;
    ic_req = 1'b1; ic_addr = a;
    wait_grant(1'b0, "ic");
    ic_req = 1'b0;
    wait_idle("ic");
    lat = last_ic_resp_cyc + 1 - t0;
  endtask

  task automatic do_lsb(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] ty, input logic [3:0] id, input logic [31:0] raw,
                        input logic [31:0] exp);
    fix_en = 1'b1; fix_val = raw;
    grant_q.push_back(1'b1);
    push_resp(1'b1, exp, id);
    @(posedge clk); #1;
    lsb_req = 1'b1; lsb_we = we; lsb_addr = a; lsb_wdata = wd; lsb_type = ty; lsb_id = id;
    wait_grant(1'b1, "lsb");
    lsb_req = 1'b0;
    wait_idle("lsb");
  endtask

  initial begin
    int lat, g0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", 64'(outs_any()), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // icache only, latency
    eng_lat = 4;
    do_ic(32'h100, 32'h00A00093, lat);
    chk("ic_latency", 64'(lat), 64'd7);

    // Both requesting continuously: L,L,L,L,I repeated
    fix_en = 1'b0; eng_lat = 1;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) begin
        grant_q.push_back(1'b0); push_resp(1'b0, model_rd(32'h200), 4'd0);
      end else begin
        grant_q.push_back(1'b1); push_resp(1'b1, model_rd(32'h40), 4'd3);
      end
    end
    @(posedge clk); #1;
    g0 = ngrant;
    ic_req = 1'b1; ic_addr = 32'h200;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h40; lsb_type = 3'b010; lsb_id = 4'd3;
    for (int k = 0; k < 400; k++) begin
      if (ngrant >= g0 + 10) break;
      @(posedge clk);
    end
    #1;
    ic_req = 1'b0; lsb_req = 1'b0;
    chk("cont_grants", 64'(ngrant - g0), 64'd10);
    wait_idle("cont");

    // Load extension
    eng_lat = 2;
    do_lsb(1'b0, 32'h80, 32'h0, 3'b000, 4'd5, 32'h000000F0, 32'hFFFFFFF0);
    do_lsb(1'b0, 32'h84, 32'h0, 3'b100, 4'd6, 32'h000000F0, 32'h000000F0);
    do_lsb(1'b0, 32'h88, 32'h0, 3'b001, 4'd7, 32'h12348001, 32'hFFFF8001);
    do_lsb(1'b0, 32'h8C, 32'h0, 3'b101, 4'd8, 32'h12348001, 32'h00008001);
    do_lsb(1'b0, 32'h90, 32'h0, 3'b010, 4'd9, 32'h87654321, 32'h87654321);
    do_lsb(1'b1, 32'h94, 32'hCAFEF00D, 3'b010, 4'd2, 32'h0, 32'h0);

    // IO store blocked while buffer full; icache goes first
    fix_en = 1'b1; fix_val = 32'h11112222;
    grant_q.push_back(1'b0); push_resp(1'b0, 32'h11112222, 4'd0);
    @(posedge clk); #1;
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h30000; lsb_wdata = 32'h55; lsb_type = 3'b010; lsb_id = 4'd1;
    ic_req = 1'b1; ic_addr = 32'h300;
    wait_grant(1'b0, "io_ic");
    ic_req = 1'b0;
    wait_idle("io_ic");
    repeat (5) @(posedge clk);
    #1;
    chk("io_stall_busy", 64'(busy), 64'd0);
    grant_q.push_back(1'b1); push_resp(1'b1, 32'h0, 4'd1);
    io_buffer_full = 1'b0;
    wait_grant(1'b1, "io_st");
    lsb_req = 1'b0;
    wait_idle("io_st");

    // Flush during WAIT of a load: response suppressed
    eng_lat = 6; fix_val = 32'hABCD0001;
    grant_q.push_back(1'b1);
    @(posedge clk); #1;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'hA0; lsb_type = 3'b010; lsb_id = 4'd4;
    wait_grant(1'b1, "fl_ld");
    lsb_req = 1'b0;
    repeat (2) @(posedge clk);
    #1; flush_in = 1'b1;
    @(posedge clk); #1; flush_in = 1'b0;
    wait_done("fl_ld");
    @(posedge clk); #1;
    chk("fl_ld_busy_resp", 64'(busy), 64'd1);
    chk("fl_ld_noresp", 64'(lsb_resp), 64'd0);
    @(posedge clk); #1;
    chk("fl_ld_busy_drop", 64'(busy), 64'd0);

    // Flush during WAIT of a store: response still issued
    grant_q.push_back(1'b1); push_resp(1'b1, 32'h0, 4'd2);
    @(posedge clk); #1;
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'hB0; lsb_wdata = 32'h77; lsb_id = 4'd2;
    wait_grant(1'b1, "fl_st");
    lsb_req = 1'b0;
    repeat (2) @(posedge clk);
    #1; flush_in = 1'b1;
    @(posedge clk); #1; flush_in = 1'b0;
    wait_idle("fl_st");

    // Flush coinciding with eng_done: response suppressed
    eng_lat = 3;
    grant_q.push_back(1'b0);
    @(posedge clk); #1;
    ic_req = 1'b1; ic_addr = 32'h500;
    wait_grant(1'b0, "fl_dn");
    ic_req = 1'b0;
    wait_done("fl_dn");
    flush_in = 1'b1;
    @(posedge clk); #1; flush_in = 1'b0;
    chk("fl_dn_noresp", 64'(ic_resp), 64'd0);
    wait_idle("fl_dn");

    // Flush in IDLE blocks that cycle's grant
    fix_val = 32'h0BADF00D;
    grant_q.push_back(1'b0); push_resp(1'b0, 32'h0BADF00D, 4'd0);
    @(posedge clk); #1;
    ic_req = 1'b1; ic_addr = 32'h600; flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    chk("fl_idle_nogrant", 64'(ic_grant), 64'd0);
    @(posedge clk); #1;
    chk("fl_idle_grant_next", 64'(ic_grant), 64'd1);
    ic_req = 1'b0;
    wait_idle("fl_idle");

    // rdy_in low freezes the ISSUE pulses
    eng_lat = 2; fix_val = 32'h600DCAFE;
    grant_q.push_back(1'b0); push_resp(1'b0, 32'h600DCAFE, 4'd0);
    @(posedge clk); #1;
    ic_req = 1'b1; ic_addr = 32'h700;
    wait_grant(1'b0, "rdy");
    ic_req = 1'b0;
    rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rdy_hold_start", 64'(eng_start), 64'd1);
    chk("rdy_hold_grant", 64'(ic_grant), 64'd1);
    rdy = 1'b1;
    wait_idle("rdy");

    // Asynchronous reset in WAIT
    eng_lat = 8;
    grant_q.push_back(1'b0);
    @(posedge clk); #1;
    ic_req = 1'b1; ic_addr = 32'h800;
    wait_grant(1'b0, "arst");
    ic_req = 1'b0;
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("arst_outs", 64'(outs_any()), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    eng_lat = 2;
    do_ic(32'h400, 32'h00000013, lat);
    chk("post_rst_latency", 64'(lat), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
